// File: rtl/shift_seq_pkg.sv
// Shared ALU definitions for the shift sequencer: accumulator width,
// shift-amount width and the sequencer state encodings.
package shift_seq_pkg;

    localparam int SSQ_WIDTH = 56;   // accumulator ext:msb:lsb, bits 55:0
    localparam int SSQ_CNTW  = 6;    // shift-amount width

    typedef logic [SSQ_WIDTH-1:0] acc_t;

    typedef enum logic [1:0] {
        SSQ_IDLE  = 2'd0,
        SSQ_SHIFT = 2'd1,
        SSQ_DONE  = 2'd2
    } ssq_state_e;

endpackage

// File: rtl/shift_seq_shift1.sv
// One-bit arithmetic shifter from the ALU. Purely combinational: left shift
// fills with zero, right shift fills with the sign bit. ovf flags a left step
// that changes the sign (the two top bits differ before the step).
module shift1
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SSQ_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             left,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    // select shift direction; right shifts can never overflow
    always_comb begin
        if (left) begin
            dout = {din[WIDTH-2:0], 1'b0};
            ovf  = din[WIDTH-1] ^ din[WIDTH-2];
        end else begin
            dout = {din[WIDTH-1], din[WIDTH-1:1]};
            ovf  = 1'b0;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-bit arithmetic shift sequencer: performs an N-bit shift one bit per
// clock through a single shift1 instance, then pulses done with the result.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   SSQ_IDLE  | waiting for start; dout holds the last result
//   SSQ_SHIFT | one bit shifted per clock, count counts down to zero
//   SSQ_DONE  | one-cycle result pulse; a start here is accepted at once
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SSQ_WIDTH,
    parameter int CNTW  = SSQ_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNTW-1:0]  amount,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    ssq_state_e       state;
    ssq_state_e       state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic             sh_ovf;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  amt_clamped;
    logic             dir_q;
    logic             ovf_q;
    logic             accept;

    // amounts beyond the accumulator width behave as a full-width shift
    assign amt_clamped = (amount > CNTW'(WIDTH)) ? CNTW'(WIDTH) : amount;
    assign accept      = start && ((state == SSQ_IDLE) || (state == SSQ_DONE));

    shift1 #(.WIDTH(WIDTH)) u_shift1 (
        .din  (shreg),
        .left (dir_q),
        .dout (sh_next),
        .ovf  (sh_ovf)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= SSQ_IDLE;
        else       state <= state_nx;
    end

    // capture a new request, or advance the shift one bit and count down
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
            dir_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            shreg <= din;
            count <= amt_clamped;
            dir_q <= dir;
            ovf_q <= 1'b0;
        end else if (state == SSQ_SHIFT) begin
            shreg <= sh_next;
            count <= count - CNTW'(1);
            if (sh_ovf) ovf_q <= 1'b1;
        end
    end

    // next-state decode; zero-length requests go straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            SSQ_IDLE: begin
                if (start) state_nx = (amt_clamped == '0) ? SSQ_DONE : SSQ_SHIFT;
            end
            SSQ_SHIFT: begin
                if (count <= CNTW'(1)) state_nx = SSQ_DONE;
            end
            SSQ_DONE: begin
                if (start) state_nx = (amt_clamped == '0) ? SSQ_DONE : SSQ_SHIFT;
                else       state_nx = SSQ_IDLE;
            end
            default: state_nx = SSQ_IDLE;
        endcase
    end

    // state-decoded outputs; dout always mirrors the shift register
    always_comb begin
        busy = (state == SSQ_SHIFT);
        done = (state == SSQ_DONE);
        dout = shreg;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: a whole-operation model (result of a
// k-bit shift computed with plain arithmetic) checked every cycle, plus
// directed operations with hand-computed literal results and latencies.
module tb_shift_seq;

    localparam int W = 56;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         dir;
    logic [5:0]   amount;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         busy;
    logic         done;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;

    shift_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dir    (dir),
        .amount (amount),
        .din    (din),
        .dout   (dout),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // value of d after k one-bit arithmetic shifts
    function automatic logic [W-1:0] shift_by(input logic [W-1:0] d, input logic left, input int k);
        logic signed [W-1:0] s;
        if (left) return d << k;
        s = d;
        return s >>> k;
    endfunction

    // a left shift overflowed iff shifting back arithmetically does not restore d
    function automatic logic ovf_by(input logic [W-1:0] d, input logic left, input int k);
        logic signed [W-1:0] s;
        if (!left) return 1'b0;
        s = d << k;
        return (W'(s >>> k) != d);
    endfunction

    // model: operand, direction, clamped length, edges since accept
    logic [W-1:0] m_din;
    logic         m_dir;
    int           m_n;
    int           m_k;
    logic         m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_din   = '0;
            m_dir   = 1'b0;
            m_n     = 0;
            m_k     = 2;
        end else if (m_valid && start && m_k >= m_n) begin
            m_din = din;
            m_dir = dir;
            m_n   = (int'(amount) > W) ? W : int'(amount);
            m_k   = 0;
        end else if (m_k < 1000) begin
            m_k++;
        end
    end

    always @(negedge clk) begin
        int kk;
        logic [63:0] exp_v;
        logic [63:0] act_v;
        if (m_valid) begin
            kk    = (m_k < m_n) ? m_k : m_n;
            exp_v = {5'd0, (m_k < m_n), (m_k == m_n), ovf_by(m_din, m_dir, kk), shift_by(m_din, m_dir, kk)};
            act_v = {5'd0, busy, done, ovf, dout};
            chk("cycle busy/done/ovf/dout", act_v, exp_v);
        end
    end

    // issue one request at #1 after an edge and wait (bounded) for done;
    // optionally pulse a stray start at iteration glitch_at
    task automatic run_op(input logic [W-1:0] d, input logic dr, input logic [5:0] a,
                          input int glitch_at, output int lat, output int bc,
                          output logic [W-1:0] res, output logic ov);
        start = 1'b1; din = d; dir = dr; amount = a;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        bc  = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bc++;
            if (i == glitch_at) begin
                start = 1'b1; din = 56'h1; dir = 1'b1; amount = 6'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        res = dout;
        ov  = ovf;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        logic [W-1:0] res;
        logic ov;

        reset = 1'b1; start = 1'b0; dir = 1'b0; amount = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", 64'(dout), 64'h0);
        chk("reset busy/done/ovf", {61'd0, busy, done, ovf}, 64'h0);
        reset = 1'b0;
        idle_cycle();

        // 1: reset during a 20-bit left shift that has already overflowed
        start = 1'b1; din = 56'h40000000000000; dir = 1'b1; amount = 6'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t1 busy before reset", 64'(busy), 64'h1);
        chk("t1 ovf before reset", 64'(ovf), 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t1 outputs after reset", {5'd0, busy, done, ovf, dout}, 64'h0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        chk("t1 no done after reset", 64'(pulses), 64'h0);

        // 2: 1 << 4
        run_op(56'h00000000000001, 1'b1, 6'd4, -1, lat, bc, res, ov);
        chk("t2 latency", 64'(lat), 64'd4);
        chk("t2 busy cycles", 64'(bc), 64'd4);
        chk("t2 dout", 64'(res), 64'h10);
        chk("t2 ovf", 64'(ov), 64'h0);
        idle_cycle();

        // 3: sign-fill right shift by 3
        run_op(56'h80000000000000, 1'b0, 6'd3, -1, lat, bc, res, ov);
        chk("t3 busy cycles", 64'(bc), 64'd3);
        chk("t3 dout", 64'(res), 64'h00F0000000000000);
        idle_cycle();

        // 4: sign change sets ovf; next start clears it
        run_op(56'h40000000000000, 1'b1, 6'd1, -1, lat, bc, res, ov);
        chk("t4a dout", 64'(res), 64'h0080000000000000);
        chk("t4a ovf", 64'(ov), 64'h1);
        idle_cycle();
        run_op(56'h1, 1'b1, 6'd1, -1, lat, bc, res, ov);
        chk("t4b dout", 64'(res), 64'h2);
        chk("t4b ovf", 64'(ov), 64'h0);
        idle_cycle();

        // 5: zero amount, then back-to-back start in the DONE cycle
        run_op(56'h123456789ABCDE, 1'b0, 6'd0, -1, lat, bc, res, ov);
        chk("t5 latency", 64'(lat), 64'd0);
        chk("t5 busy cycles", 64'(bc), 64'd0);
        chk("t5 dout", 64'(res), 64'h00123456789ABCDE);
        run_op(56'h2, 1'b0, 6'd1, -1, lat, bc, res, ov);
        chk("t5 b2b latency", 64'(lat), 64'd1);
        chk("t5 b2b dout", 64'(res), 64'h1);
        idle_cycle();

        // 6: clamped right shift with a stray start mid-operation
        run_op(56'h80000000000000, 1'b0, 6'd63, 10, lat, bc, res, ov);
        chk("t6 busy cycles", 64'(bc), 64'd56);
        chk("t6 latency", 64'(lat), 64'd56);
        chk("t6 dout", 64'(res), 64'h00FFFFFFFFFFFFFF);
        chk("t6 ovf", 64'(ov), 64'h0);
        idle_cycle();

        // clamped left shifts: result 0, ovf whenever the operand is nonzero
        run_op(56'h1, 1'b1, 6'd60, -1, lat, bc, res, ov);
        chk("clamp left dout", 64'(res), 64'h0);
        chk("clamp left ovf", 64'(ov), 64'h1);
        chk("clamp left busy", 64'(bc), 64'd56);
        idle_cycle();
        run_op(56'hFFFFFFFFFFFFFF, 1'b1, 6'd3, -1, lat, bc, res, ov);
        chk("neg left dout", 64'(res), 64'h00FFFFFFFFFFFFF8);
        chk("neg left ovf", 64'(ov), 64'h0);
        idle_cycle();
        run_op(56'h7FFFFFFFFFFFFF, 1'b0, 6'd56, -1, lat, bc, res, ov);
        chk("pos right full dout", 64'(res), 64'h0);
        repeat (3) idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
Multi-bit arithmetic shift sequencer for the DSP ALU.
- Accepts a shift request (direction plus amount) on the 56-bit accumulator datapath.
- Performs the shift one bit per clock by driving a single one-bit arithmetic shifter, then returns the result with a done pulse.
- Sits between ALU instruction decode and the accumulator writeback mux; replaces a 56-bit barrel shifter to save area.

Parameters:
- WIDTH, 56, accumulator width (ext:msb:lsb); must match `acc.
- CNTW, 6, shift-amount width; requests above WIDTH are clamped to WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when accepting (IDLE or DONE).
- dir  input  1  1 = arithmetic left, 0 = arithmetic right; captured with start.
- amount  input  CNTW  number of bit positions; captured with start.
- din  input  WIDTH  operand; captured with start.
- dout  output  WIDTH  shifted result; valid while done = 1, held until the next accepted start.
- busy  output  1  high while shifting (SHIFT state).
- done  output  1  one-cycle pulse; result valid.
- ovf  output  1  sticky left-shift overflow flag for the current operation.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. While reset = 1 at a clk edge: state = IDLE, dout = 0, busy = 0, done = 0, ovf = 0, count = 0.
- Reset mid-operation: the operation is discarded; no done is produced.
- States: IDLE, SHIFT, DONE, 2-bit encoding. busy = (state == SHIFT); done = (state == DONE).
- Accepting a request: a start is accepted in IDLE or DONE. At accepting edge T0:
  - shift register = din; dir is latched; ovf = 0.
  - count = min(amount, WIDTH).
  - next state = SHIFT if count > 0, else DONE.
- Start while in SHIFT: ignored. There is no queueing and no error flag.
- SHIFT, each edge:
  - shift register = one-bit shifter output (left = dir, right = ~dir).
  - count decrements by 1.
  - The transition from count == 1 goes to DONE.
- Shift semantics:
  - Left: {r[54:0], 0}.
  - Right: {r[55], r[55:1]}, i.e. sign fill.
- Overflow: on each left step, if r[55] != r[54] before the step, ovf is set. ovf stays set until the next accepted start. Right shifts never set ovf.
- Latency: with N = min(amount, 56), done is high in exactly the one cycle following edge T0 + N. For N = 0, that is the cycle after T0.
  - busy is high for N cycles.
  - Worst case: 57 cycles from start to done.
- DONE:
  - With no start, it returns to IDLE on the next edge.
  - With a start, it accepts back-to-back: same edge, goes to SHIFT or DONE.
- Output holding: dout mirrors the shift register in all states. It is therefore stable and valid from the done cycle until the next accepted start.
- Clamp: amount 57..63 behaves exactly as 56.
  - Left result is 0.
  - Right result is 56 copies of din[55].

Decomposition:
- Shared ALU header holds:
  - `acc (55:0)
  - state encodings (`SSQ_IDLE, `SSQ_SHIFT, `SSQ_DONE)
  - the shift-amount width
- One sub-module: the existing ALU one-bit arithmetic shifter shift1, instantiated once. It is combinational, fed from the shift register, with its output registered in this block.
- FSM, counter and ovf logic stay in shift_seq.

Test Plan:
1. Reset held during SHIFT with amount = 20 → next cycle dout = 0, busy = 0, done = 0, ovf = 0; no later done pulse.
2. din = 0x00000000000001, dir = 1, amount = 4 → busy high 4 cycles; done in cycle 5 after the start edge; dout = 0x00000000000010; ovf = 0.
3. din = 0x80000000000000, dir = 0, amount = 3 → dout = 0xF0000000000000; done after 3 busy cycles.
4. din = 0x40000000000000, dir = 1, amount = 1 → dout = 0x80000000000000, ovf = 1. Then start with din = 0x1, dir = 1, amount = 1 → ovf = 0, dout = 0x2.
5. amount = 0, din = 0x123456789ABCDE → done in the cycle after start; dout = din; busy never asserted. Back-to-back start in the DONE cycle is accepted.
6. din = 0x80000000000000, dir = 0, amount = 63 → exactly 56 busy cycles, dout = 0xFFFFFFFFFFFFFF. A start pulsed mid-operation is ignored.
